pong_engine: RTL and testbench

//  Two-player Pong game core, successor to the single-paddle demo top. Holds two paddle

---
 rtl/pong_engine.sv | 218 +++++++++++++++++++++
 tb/tb_pong_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// Two-player Pong core: paddles, ball motion/bounce, scoring, serve delay and game-over,
// plus a registered pixel colour for the VGA driver. Everything runs on pixel_clk.
module pong_engine #(
  parameter int COORD_W     = 10,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int PADDLE_W    = 5,
  parameter int PADDLE_H    = 50,
  parameter int BALL_SIZE   = 4,
  parameter int PADDLE_DIV  = 100000,
  parameter int BALL_DIV    = 200000,
  parameter int SERVE_DELAY = 60,
  parameter int SCORE_MAX   = 9
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               p1_up,
  input  logic               p1_dn,
  input  logic               p2_up,
  input  logic               p2_dn,
  input  logic [COORD_W-1:0] X_pix,
  input  logic [COORD_W-1:0] Y_pix,
  output logic [COORD_W-1:0] p1_y,
  output logic [COORD_W-1:0] p2_y,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [3:0]         score_p1,
  output logic [3:0]         score_p2,
  output logic               game_over,
  output logic [11:0]        pixel_color
);
  localparam int CW  = COORD_W + 1;
  localparam int PCW = (PADDLE_DIV > 1) ? $clog2(PADDLE_DIV) : 1;
  localparam int BCW = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;
  localparam int SCW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [1:0] S_SERVE = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_SCORE = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [COORD_W-1:0] PAD_Y0     = COORD_W'((V_RES - PADDLE_H) / 2);
  localparam logic [COORD_W-1:0] PAD_MAX    = COORD_W'(V_RES - PADDLE_H);
  localparam logic [COORD_W-1:0] BALL_X0    = COORD_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] BALL_Y0    = COORD_W'((V_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] BALL_X_MAX = COORD_W'(H_RES - BALL_SIZE);
  localparam logic [COORD_W-1:0] BALL_Y_MAX = COORD_W'(V_RES - BALL_SIZE);
  localparam logic [COORD_W-1:0] HIT_L      = COORD_W'(PADDLE_W);
  localparam logic [COORD_W-1:0] HIT_R      = COORD_W'(H_RES - PADDLE_W - BALL_SIZE);
  localparam logic [COORD_W-1:0] P2_X       = COORD_W'(H_RES - PADDLE_W);
  localparam logic [COORD_W-1:0] NET_L      = COORD_W'(H_RES / 2 - 1);
  localparam logic [COORD_W-1:0] NET_R      = COORD_W'(H_RES / 2);
  localparam logic [CW-1:0]      PW_E       = CW'(PADDLE_W);
  localparam logic [CW-1:0]      PH_E       = CW'(PADDLE_H);
  localparam logic [CW-1:0]      BS_E       = CW'(BALL_SIZE);
  localparam logic [3:0]         SMAX       = 4'(SCORE_MAX);

  logic [PCW-1:0]     pcnt_q;
  logic [BCW-1:0]     bcnt_q;
  logic [SCW-1:0]     serve_q, serve_d;
  logic [1:0]         state_q, state_d;
  logic               scorer_p2_q, scorer_p2_d;
  logic [COORD_W-1:0] p1_q, p1_d, p2_q, p2_d, bx_q, bx_d, by_q, by_d;
  logic               dxl_q, dxl_d, dyu_q, dyu_d;   // 1 = moving left / up
  logic [3:0]         s1_q, s1_d, s2_q, s2_d;
  logic [11:0]        pix_q, pix_d;
  logic               paddle_tick, ball_tick;

  assign paddle_tick = (pcnt_q == PCW'(PADDLE_DIV - 1));
  assign ball_tick   = (bcnt_q == BCW'(BALL_DIV - 1));

  function automatic logic [COORD_W-1:0] pad_step(input logic [COORD_W-1:0] y,
                                                  input logic up, input logic dn);
    logic [COORD_W-1:0] r;
    r = y;
    if (up && !dn && y != '0) r = y - 1'b1;
    else if (dn && !up && y != PAD_MAX) r = y + 1'b1;
    return r;
  endfunction

  function automatic logic overlap(input logic [COORD_W-1:0] by, input logic [COORD_W-1:0] py);
    logic [CW-1:0] b, p;
    b = {1'b0, by};
    p = {1'b0, py};
    return ((b + BS_E) > p) && (b < (p + PH_E));
  endfunction

  function automatic logic in_box(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                  input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                                  input logic [CW-1:0] w, input logic [CW-1:0] h);
    return ({1'b0, px} >= {1'b0, x}) && ({1'b0, px} < ({1'b0, x} + w)) &&
           ({1'b0, py} >= {1'b0, y}) && ({1'b0, py} < ({1'b0, y} + h));
  endfunction

  always_comb begin
    state_d     = state_q;
    serve_d     = serve_q;
    scorer_p2_d = scorer_p2_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    bx_d        = bx_q;
    by_d        = by_q;
    dxl_d       = dxl_q;
    dyu_d       = dyu_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    if (state_q != S_OVER && paddle_tick) begin
      p1_d = pad_step(p1_q, p1_up, p1_dn);
      p2_d = pad_step(p2_q, p2_up, p2_dn);
    end
    case (state_q)
      S_SERVE: if (ball_tick) begin
        if (serve_q == SCW'(SERVE_DELAY - 1)) begin
          state_d = S_PLAY;
          serve_d = '0;
        end else begin
          serve_d = serve_q + 1'b1;
        end
      end
      S_PLAY: if (ball_tick) begin
        if (dyu_q && by_q == '0) begin
          dyu_d = 1'b0;
          by_d  = COORD_W'(1);
        end else if (!dyu_q && by_q == BALL_Y_MAX) begin
          dyu_d = 1'b1;
          by_d  = by_q - 1'b1;
        end else begin
          by_d = dyu_q ? by_q - 1'b1 : by_q + 1'b1;
        end
        // Paddle hits take priority; the hit test sees the pre-edge paddle positions.
        if (dxl_q && bx_q == HIT_L && overlap(by_q, p1_q)) begin
          dxl_d = 1'b0;
          bx_d  = bx_q + 1'b1;
        end else if (!dxl_q && bx_q == HIT_R && overlap(by_q, p2_q)) begin
          dxl_d = 1'b1;
          bx_d  = bx_q - 1'b1;
        end else if (dxl_q && bx_q == '0) begin
          state_d     = S_SCORE;
          scorer_p2_d = 1'b1;
        end else if (!dxl_q && bx_q == BALL_X_MAX) begin
          state_d     = S_SCORE;
          scorer_p2_d = 1'b0;
        end else begin
          bx_d = dxl_q ? bx_q - 1'b1 : bx_q + 1'b1;
        end
      end
      S_SCORE: begin
        bx_d    = BALL_X0;
        by_d    = BALL_Y0;
        dyu_d   = 1'b0;
        dxl_d   = scorer_p2_q;
        serve_d = '0;
        if (scorer_p2_q) begin
          s2_d    = (s2_q == SMAX) ? s2_q : s2_q + 1'b1;
          state_d = (s2_d == SMAX) ? S_OVER : S_SERVE;
        end else begin
          s1_d    = (s1_q == SMAX) ? s1_q : s1_q + 1'b1;
          state_d = (s1_d == SMAX) ? S_OVER : S_SERVE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pix_d = 12'h000;
    if (in_box(X_pix, Y_pix, COORD_W'(0), p1_q, PW_E, PH_E) ||
        in_box(X_pix, Y_pix, P2_X, p2_q, PW_E, PH_E))
      pix_d = 12'h0F0;
    else if (in_box(X_pix, Y_pix, bx_q, by_q, BS_E, BS_E))
      pix_d = 12'hFFF;
    else if ((X_pix == NET_L || X_pix == NET_R) && !Y_pix[3])
      pix_d = 12'h888;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q      <= '0;
      bcnt_q      <= '0;
      serve_q     <= '0;
      state_q     <= S_SERVE;
      scorer_p2_q <= 1'b0;
      p1_q        <= PAD_Y0;
      p2_q        <= PAD_Y0;
      bx_q        <= BALL_X0;
      by_q        <= BALL_Y0;
      dxl_q       <= 1'b1;
      dyu_q       <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      pix_q       <= '0;
    end else begin
      pcnt_q      <= paddle_tick ? '0 : pcnt_q + 1'b1;
      bcnt_q      <= ball_tick ? '0 : bcnt_q + 1'b1;
      serve_q     <= serve_d;
      state_q     <= state_d;
      scorer_p2_q <= scorer_p2_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dxl_q       <= dxl_d;
      dyu_q       <= dyu_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      pix_q       <= pix_d;
    end
  end

  assign p1_y        = p1_q;
  assign p2_y        = p2_q;
  assign ball_x      = bx_q;
  assign ball_y      = by_q;
  assign score_p1    = s1_q;
  assign score_p2    = s2_q;
  assign game_over   = (state_q == S_OVER);
  assign pixel_color = pix_q;
endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: cycle-level game model compared every cycle, directed
// corner-case sequences, and a table of pixel-colour vectors on a frozen board.
module tb_pong_engine;
  localparam int CW = 10, H = 640, V = 480, PW = 5, PH = 50, BS = 4;
  localparam int PDIV = 1, BDIV = 2, SD = 2, SMAX = 3;

  logic clk, rst_n;
  logic p1_up, p1_dn, p2_up, p2_dn;
  logic [CW-1:0] X_pix, Y_pix;
  logic [CW-1:0] p1_y, p2_y, ball_x, ball_y;
  logic [3:0] score_p1, score_p2;
  logic game_over;
  logic [11:0] pixel_color;

  pong_engine #(.COORD_W(CW), .H_RES(H), .V_RES(V), .PADDLE_W(PW), .PADDLE_H(PH),
                .BALL_SIZE(BS), .PADDLE_DIV(PDIV), .BALL_DIV(BDIV),
                .SERVE_DELAY(SD), .SCORE_MAX(SMAX)) dut (
    .pixel_clk(clk), .rst_n(rst_n),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .X_pix(X_pix), .Y_pix(Y_pix),
    .p1_y(p1_y), .p2_y(p2_y), .ball_x(ball_x), .ball_y(ball_y),
    .score_p1(score_p1), .score_p2(score_p2),
    .game_over(game_over), .pixel_color(pixel_color));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  bit chk_on = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_SERVE, M_PLAY, M_SCORE, M_OVER} mphase_e;
  mphase_e m_ph;
  int m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_ticks, m_cyc, m_pix, m_scorer;

  function automatic bit box(int px, int py, int x, int y, int w, int h);
    return px >= x && px < x + w && py >= y && py < y + h;
  endfunction

  function automatic int color_of(int px, int py);
    if (box(px, py, 0, m_p1, PW, PH) || box(px, py, H - PW, m_p2, PW, PH)) return 'h0F0;
    if (box(px, py, m_bx, m_by, BS, BS)) return 'hFFF;
    if ((px == H / 2 - 1 || px == H / 2) && ((py / 8) % 2 == 0)) return 'h888;
    return 0;
  endfunction

  function automatic int pad_move(int y, bit up, bit dn);
    if (up && !dn) return (y > 0) ? y - 1 : 0;
    if (dn && !up) return (y < V - PH) ? y + 1 : V - PH;
    return y;
  endfunction

  task automatic model_reset();
    m_p1 = (V - PH) / 2; m_p2 = (V - PH) / 2;
    m_bx = (H - BS) / 2; m_by = (V - BS) / 2;
    m_dx = -1; m_dy = 1; m_s1 = 0; m_s2 = 0;
    m_ticks = 0; m_cyc = 0; m_pix = 0; m_scorer = 0; m_ph = M_SERVE;
  endtask

  task automatic model_step();
    int np1 = m_p1, np2 = m_p2, nbx = m_bx, nby = m_by, ndx = m_dx, ndy = m_dy;
    bit pt, bt, hit1, hit2;
    pt = (m_cyc % PDIV) == PDIV - 1;
    bt = (m_cyc % BDIV) == BDIV - 1;
    m_pix = color_of(int'(X_pix), int'(Y_pix));
    if (m_ph != M_OVER && pt) begin
      np1 = pad_move(m_p1, p1_up, p1_dn);
      np2 = pad_move(m_p2, p2_up, p2_dn);
    end
    case (m_ph)
      M_SERVE: if (bt) begin
        m_ticks++;
        if (m_ticks == SD) begin m_ph = M_PLAY; m_ticks = 0; end
      end
      M_PLAY: if (bt) begin
        if (m_dy < 0 && m_by == 0) begin ndy = 1; nby = 1; end
        else if (m_dy > 0 && m_by == V - BS) begin ndy = -1; nby = m_by - 1; end
        else nby = m_by + m_dy;
        hit1 = (m_by + BS > m_p1) && (m_by < m_p1 + PH);
        hit2 = (m_by + BS > m_p2) && (m_by < m_p2 + PH);
        if (m_dx < 0 && m_bx == PW && hit1) begin ndx = 1; nbx = m_bx + 1; end
        else if (m_dx > 0 && m_bx == H - PW - BS && hit2) begin ndx = -1; nbx = m_bx - 1; end
        else if (m_dx < 0 && m_bx == 0) begin m_ph = M_SCORE; m_scorer = 2; end
        else if (m_dx > 0 && m_bx == H - BS) begin m_ph = M_SCORE; m_scorer = 1; end
        else nbx = m_bx + m_dx;
      end
      M_SCORE: begin
        bit over;
        if (m_scorer == 2) begin
          m_s2 = (m_s2 < SMAX) ? m_s2 + 1 : SMAX; over = (m_s2 == SMAX); ndx = -1;
        end else begin
          m_s1 = (m_s1 < SMAX) ? m_s1 + 1 : SMAX; over = (m_s1 == SMAX); ndx = 1;
        end
        nbx = (H - BS) / 2; nby = (V - BS) / 2; ndy = 1; m_ticks = 0;
        m_ph = over ? M_OVER : M_SERVE;
      end
      default: ;
    endcase
    m_p1 = np1; m_p2 = np2; m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy;
    m_cyc++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on && rst_n) begin
      n_tests++;
      if (int'(p1_y) != m_p1 || int'(p2_y) != m_p2 || int'(ball_x) != m_bx ||
          int'(ball_y) != m_by || int'(score_p1) != m_s1 || int'(score_p2) != m_s2 ||
          int'(game_over) != int'(m_ph == M_OVER) || int'(pixel_color) != m_pix) begin
        n_fail++;
        $display("FAIL model t=%0t (dut/model): p1 %0d/%0d p2 %0d/%0d bx %0d/%0d by %0d/%0d s1 %0d/%0d s2 %0d/%0d go %0d/%0d pix %h/%h",
                 $time, p1_y, m_p1, p2_y, m_p2, ball_x, m_bx, ball_y, m_by,
                 score_p1, m_s1, score_p2, m_s2, game_over, (m_ph == M_OVER), pixel_color, m_pix[11:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  // p1 mode: 0 idle, 1 up, 2 down, 3 both, 4 random; p2 mode: 0 idle, 4 random, 5 track ball
  task automatic drive(input int p1m, input int p2m);
    int c, t;
    p1_up = (p1m == 1 || p1m == 3) || (p1m == 4 && $urandom_range(0, 1) == 1);
    p1_dn = (p1m == 2 || p1m == 3) || (p1m == 4 && $urandom_range(0, 1) == 1);
    if (p2m == 5) begin
      c = int'(p2_y) + PH / 2;
      t = int'(ball_y) + BS / 2;
      p2_up = c > t + 1;
      p2_dn = c < t - 1;
    end else begin
      p2_up = (p2m == 4) && $urandom_range(0, 1) == 1;
      p2_dn = (p2m == 4) && $urandom_range(0, 1) == 1;
    end
    if ($urandom_range(0, 3) == 0) X_pix = CW'($urandom_range(H - 10, H - 1));
    else X_pix = CW'($urandom_range(0, H - 1));
    Y_pix = CW'($urandom_range(0, V - 1));
  endtask

  task automatic run(input int n, input int p1m, input int p2m);
    for (int i = 0; i < n; i++) begin
      drive(p1m, p2m);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_p1_y"}, int'(p1_y), 215);
    check({tag, "_p2_y"}, int'(p2_y), 215);
    check({tag, "_ball_x"}, int'(ball_x), 318);
    check({tag, "_ball_y"}, int'(ball_y), 238);
    check({tag, "_score_p1"}, int'(score_p1), 0);
    check({tag, "_score_p2"}, int'(score_p2), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
    check({tag, "_pixel"}, int'(pixel_color), 0);
  endtask

  typedef struct { int x; int y; int color; } pix_vec_t;
  pix_vec_t vecs[17];

  initial begin
    int k, prev_s2;
    vecs[0]  = '{0, 0, 'h0F0};     vecs[1]  = '{4, 49, 'h0F0};
    vecs[2]  = '{5, 10, 'h000};    vecs[3]  = '{2, 50, 'h000};
    vecs[4]  = '{318, 238, 'hFFF}; vecs[5]  = '{321, 241, 'hFFF};
    vecs[6]  = '{322, 241, 'h000}; vecs[7]  = '{317, 238, 'h000};
    vecs[8]  = '{320, 242, 'h888}; vecs[9]  = '{319, 0, 'h888};
    vecs[10] = '{320, 7, 'h888};   vecs[11] = '{320, 8, 'h000};
    vecs[12] = '{319, 240, 'hFFF}; vecs[13] = '{321, 0, 'h000};
    vecs[14] = '{318, 0, 'h000};   vecs[15] = '{319, 16, 'h888};
    vecs[16] = '{319, 24, 'h000};

    rst_n = 1'b1; p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0; X_pix = '0; Y_pix = '0;
    #3 rst_n = 1'b0;
    #20 check_reset_values("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1;

    // Serve: two ball ticks at centre, first step on the third tick
    run(5, 0, 0);
    check("serve_hold_x", int'(ball_x), 318);
    check("serve_hold_y", int'(ball_y), 238);
    run(1, 0, 0);
    check("first_step_x", int'(ball_x), 317);
    check("first_step_y", int'(ball_y), 239);

    // Paddle saturation at the bottom, both-buttons hold, then park at 390
    run(260, 2, 4);
    check("p1_sat_bottom", int'(p1_y), 430);
    run(20, 3, 4);
    check("p1_both_hold", int'(p1_y), 430);
    run(40, 1, 4);
    check("p1_up_40", int'(p1_y), 390);

    // Ball reaches x=5 at y=401 after one bottom bounce; paddle at 390 returns it
    k = 0;
    while (ball_x != CW'(5) && k < 2000) begin run(1, 0, 4); k++; end
    check("reach_x5", int'(ball_x == CW'(5)), 1);
    check("y_at_x5", int'(ball_y), 401);
    k = 0;
    while (ball_x == CW'(5) && k < 10) begin run(1, 0, 4); k++; end
    check("bounce_x", int'(ball_x), 6);
    check("bounce_y", int'(ball_y), 400);
    check("bounce_no_score1", int'(score_p1), 0);
    check("bounce_no_score2", int'(score_p2), 0);

    // P1 to the top and held there; P2 tracks the ball so only P1 loses points
    run(450, 1, 5);
    check("p1_sat_top", int'(p1_y), 0);
    prev_s2 = 0;
    k = 0;
    while (!game_over && k < 40000) begin
      run(1, 1, 5);
      if (int'(score_p2) != prev_s2) begin
        check("score_centre_x", int'(ball_x), 318);
        check("score_centre_y", int'(ball_y), 238);
        prev_s2 = int'(score_p2);
      end
      k++;
    end
    check("game_over", int'(game_over), 1);
    check("final_score_p2", int'(score_p2), 3);
    check("final_score_p1", int'(score_p1), 0);

    // Frozen in OVER despite random buttons
    run(200, 4, 4);
    check("over_p1_y", int'(p1_y), 0);
    check("over_ball_x", int'(ball_x), 318);
    check("over_ball_y", int'(ball_y), 238);
    check("over_score_p2", int'(score_p2), 3);
    check("over_still", int'(game_over), 1);

    // Pixel vectors on the frozen board: p1 at y=0, ball at (318,238)
    p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0;
    for (int i = 0; i < 17; i++) begin
      X_pix = CW'(vecs[i].x);
      Y_pix = CW'(vecs[i].y);
      @(negedge clk);
      check($sformatf("pix_vec%0d", i), int'(pixel_color), vecs[i].color);
    end

    // Asynchronous reset in the middle of OVER
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_over_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(5, 0, 0);
    check("rerun_hold_x", int'(ball_x), 318);
    run(1, 0, 0);
    check("rerun_step_x", int'(ball_x), 317);
    run(50, 4, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
